// File: rtl/frame_config_writer.sv
// frame_config_writer: master side of the frame-based tile configuration bus.
// Records (address + data bit) arrive on a valid/ready stream, are screened
// for a legal block-select, buffered in a small FIFO and replayed to the tile
// as a SETUP / STROBE / HOLD write so address and data bracket every strobe.
module frame_config_writer #(
  parameter int ADDR_W     = 10,
  parameter int NUM_BLK    = 20,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic              cfg_data,
  output logic              enable,
  output logic [ADDR_W-1:0] address,
  output logic              data_in,
  output logic              busy,
  output logic              err_addr,
  input  logic              clr_err,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int REC_W = ADDR_W + 1;

  localparam logic [PTR_W:0]   FIFO_ZERO = (PTR_W+1)'(0);
  localparam logic [PTR_W:0]   FIFO_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [5:0]       BLK_LIM   = 6'(NUM_BLK);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // The block-select field sits in the top five address bits with the
  // lowest-numbered of them as the most significant select bit.
  function automatic logic [4:0] sel_field(input logic [ADDR_W-1:0] a);
    logic [4:0] s;
    s = 5'd0;
    for (int i = 0; i < 5; i++) begin
      s[4-i] = a[ADDR_W-5+i];
    end
    return s;
  endfunction

  state_t            r_state;
  state_t            w_state_nxt;

  logic [REC_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;
  logic              r_ready;

  logic              r_enable;
  logic [ADDR_W-1:0] r_address;
  logic              r_data_in;
  logic              r_busy;
  logic              r_err_addr;
  logic [CNT_W-1:0]  r_wr_count;

  logic              w_accept;
  logic              w_legal;
  logic              w_push;
  logic              w_illegal;
  logic              w_fifo_ne;
  logic              w_pop;
  logic [PTR_W:0]    w_count_nxt;
  logic              w_ready_nxt;
  logic              w_enable_nxt;
  logic              w_busy_nxt;
  logic              w_wr_inc;
  logic              w_err_nxt;

  assign w_accept  = cfg_valid & r_ready;
  assign w_legal   = ({1'b0, sel_field(cfg_addr)} < BLK_LIM);
  assign w_push    = w_accept & w_legal;
  assign w_illegal = w_accept & ~w_legal;
  assign w_fifo_ne = (r_count != FIFO_ZERO);

  // FSM state register; reset aborts any write in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: one setup, one strobe and one hold cycle per record.
  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE: begin
        if (w_fifo_ne) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SETUP:  w_state_nxt = S_STROBE;
      S_STROBE: w_state_nxt = S_HOLD;
      S_HOLD: begin
        if (w_fifo_ne) begin
          w_state_nxt = S_SETUP;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs and FIFO bookkeeping, all computed as next values for registers.
  always_comb begin
    w_pop        = 1'b0;
    w_count_nxt  = r_count;
    w_ready_nxt  = 1'b0;
    w_enable_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_wr_inc     = 1'b0;
    w_err_nxt    = r_err_addr;

    if (((r_state == S_IDLE) || (r_state == S_HOLD)) && w_fifo_ne) begin
      w_pop = 1'b1;
    end else begin
      w_pop = 1'b0;
    end

    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + FIFO_ONE;
      2'b01:   w_count_nxt = r_count - FIFO_ONE;
      default: w_count_nxt = r_count;
    endcase

    // Ready looks only at occupancy, never at cfg_valid.
    w_ready_nxt  = (w_count_nxt != FIFO_FULL);
    w_enable_nxt = (w_state_nxt == S_STROBE);
    w_busy_nxt   = (w_count_nxt != FIFO_ZERO) || (w_state_nxt != S_IDLE);
    w_wr_inc     = (r_state == S_HOLD);

    // A new illegal record outranks a simultaneous clear.
    if (w_illegal) begin
      w_err_nxt = 1'b1;
    end else if (clr_err) begin
      w_err_nxt = 1'b0;
    end else begin
      w_err_nxt = r_err_addr;
    end
  end

  // FIFO pointers, occupancy and the registered ready flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= FIFO_ZERO;
      r_ready <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
      r_count <= w_count_nxt;
      r_ready <= w_ready_nxt;
    end
  end

  // FIFO storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= {cfg_addr, cfg_data};
    end
  end

  // Tile-facing outputs; address/data only move when a record is popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable   <= 1'b0;
      r_address  <= '0;
      r_data_in  <= 1'b0;
      r_busy     <= 1'b0;
      r_err_addr <= 1'b0;
      r_wr_count <= '0;
    end else begin
      r_enable   <= w_enable_nxt;
      r_busy     <= w_busy_nxt;
      r_err_addr <= w_err_nxt;
      if (w_pop) begin
        {r_address, r_data_in} <= r_mem[r_rptr];
      end
      if (w_wr_inc) begin
        r_wr_count <= r_wr_count + CNT_ONE;
      end
    end
  end

  assign cfg_ready = r_ready;
  assign enable    = r_enable;
  assign address   = r_address;
  assign data_in   = r_data_in;
  assign busy      = r_busy;
  assign err_addr  = r_err_addr;
  assign wr_count  = r_wr_count;

endmodule

// File: tb/tb_frame_config_writer.sv
// Bench for frame_config_writer: directed records, scoreboard of expected
// tile writes checked by a separate strobe monitor, plus a small tile model.
module tb_frame_config_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [9:0]  cfg_addr = 10'd0;
  logic        cfg_data = 1'b0;
  logic        clr_err = 1'b0;

  logic        cfg_ready, enable, data_in, busy, err_addr;
  logic [9:0]  address;
  logic [15:0] wr_count;

  logic        cfg_ready4, enable4, data_in4, busy4, err_addr4;
  logic [9:0]  address4;
  logic [3:0]  wr_count4;

  frame_config_writer u_dut (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .enable(enable), .address(address),
    .data_in(data_in), .busy(busy), .err_addr(err_addr), .clr_err(clr_err),
    .wr_count(wr_count)
  );

  frame_config_writer #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready4),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .enable(enable4), .address(address4),
    .data_in(data_in4), .busy(busy4), .err_addr(err_addr4), .clr_err(clr_err),
    .wr_count(wr_count4)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [9:0] a;
    logic       d;
  } rec_t;

  rec_t sb[$];
  int   strobe_cnt = 0;
  int   strobe_cyc[$];
  int   last_acc = 0;
  bit   saw_not_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Build an address: word in bits [4:0], select in bits [5:9] with bit 5 as MSB.
  function automatic logic [9:0] mk_addr(input logic [4:0] sel, input logic [4:0] word);
    logic [9:0] a;
    a = 10'd0;
    a[4:0] = word;
    for (int i = 0; i < 5; i++) a[5+i] = sel[4-i];
    return a;
  endfunction

  function automatic logic pat(input int s, input int w);
    logic [7:0] v;
    v = 8'(s * 8 + w);
    return v[0] ^ v[3] ^ v[5] ^ v[1];
  endfunction

  // Tile model: 20 blocks x 8 words of config memory.
  logic tile_mem [20][8];
  always @(posedge clk) begin
    logic [4:0] s;
    s = {address[5], address[6], address[7], address[8], address[9]};
    if (reset_n && enable && s < 5'd20 && address[4:0] < 5'd8)
      tile_mem[s][address[2:0]] <= data_in;
  end

  // Monitor: every strobe pops the scoreboard; address/data must be stable
  // one cycle before and one cycle after the strobe.
  initial begin
    logic [10:0] prev_rec;
    logic [10:0] hold_rec;
    bit          prev_ok;
    bit          hold_pend;
    rec_t        e;
    prev_ok = 1'b0;
    hold_pend = 1'b0;
    prev_rec = 11'd0;
    hold_rec = 11'd0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_ok = 1'b0;
        hold_pend = 1'b0;
      end else begin
        if (hold_pend) begin
          chk("hold_stable", 32'({address, data_in}), 32'(hold_rec));
          hold_pend = 1'b0;
        end
        if (enable) begin
          strobe_cnt++;
          strobe_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_strobe: got strobe addr %0h at cycle %0d, expected none",
                     address, cyc);
          end else begin
            e = sb.pop_front();
            chk("strobe_rec", 32'({address, data_in}), 32'(e));
            if (prev_ok) chk("setup_stable", 32'(prev_rec), 32'({address, data_in}));
            hold_pend = 1'b1;
            hold_rec = {address, data_in};
          end
        end
        prev_rec = {address, data_in};
        prev_ok = 1'b1;
      end
    end
  end

  task automatic do_reset();
    cfg_valid = 1'b0;
    clr_err = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    sb.delete();
    chk("rst_enable", 32'(enable), 32'd0);
    chk("rst_address", 32'(address), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_addr), 32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(cfg_ready), 32'd1);
  endtask

  // Present one record; returns on the negedge after it is accepted.
  task automatic send(input logic [9:0] a, input logic d, input bit legal);
    int t;
    cfg_valid = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    t = 0;
    while (cfg_ready !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t > 0) saw_not_ready = 1'b1;
    if (t >= 100) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_timeout: got ready low for %0d cycles, expected acceptance", t);
    end else begin
      @(posedge clk);
      if (legal) sb.push_back({a, d});
      @(negedge clk);
      last_acc = cyc;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((busy !== 1'b0 || sb.size() != 0) && t < 800) begin
      @(negedge clk);
      t++;
    end
    chk("drain_in_time", 32'(t < 800), 32'd1);
  endtask

  initial begin
    int s0;
    int t;

    // Single record: select 0, word 3, data 1.
    do_reset();
    s0 = strobe_cnt;
    send(10'b00000_00011, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    @(negedge clk);
    chk("pre_strobe_en", 32'(enable), 32'd0);
    @(negedge clk);
    chk("latency_en", 32'(enable), 32'd1);
    chk("latency_cyc", 32'(cyc - last_acc), 32'd2);
    @(negedge clk);
    chk("hold_en", 32'(enable), 32'd0);
    chk("busy_in_hold", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after_hold", 32'(busy), 32'd0);
    chk("wr_count_single", 32'(wr_count), 32'd1);
    chk("addr_kept_idle", 32'(address), 32'h003);
    repeat (5) @(negedge clk);
    chk("single_strobes", 32'(strobe_cnt - s0), 32'd1);

    // Burst of 8 legal records with valid held high.
    do_reset();
    saw_not_ready = 1'b0;
    strobe_cyc.delete();
    for (int i = 0; i < 8; i++) send(mk_addr(5'(i + 1), 5'(7 - i)), 1'(i), 1'b1);
    cfg_valid = 1'b0;
    wait_drain();
    chk("burst_ready_low", 32'(saw_not_ready), 32'd1);
    chk("burst_strobes", 32'(strobe_cyc.size()), 32'd8);
    for (int k = 1; k < strobe_cyc.size(); k++)
      chk("burst_spacing", 32'(strobe_cyc[k] - strobe_cyc[k-1]), 32'd3);
    chk("burst_wr_count", 32'(wr_count), 32'd8);

    // Illegal selects 20 and 31 interleaved with legal records (incl. select 19).
    do_reset();
    send(10'b11001_00111, 1'b0, 1'b1);
    send(10'b00101_00001, 1'b1, 1'b0);
    chk("err_set_sel20", 32'(err_addr), 32'd1);
    send(10'b00000_00101, 1'b1, 1'b1);
    send(10'b11111_00010, 1'b1, 1'b0);
    send(10'b00000_01000, 1'b0, 1'b1);
    cfg_valid = 1'b0;
    wait_drain();
    chk("illegal_wr_count", 32'(wr_count), 32'd3);
    chk("err_sticky", 32'(err_addr), 32'd1);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("err_cleared", 32'(err_addr), 32'd0);
    clr_err = 1'b1;
    send(10'b00101_00110, 1'b0, 1'b0);
    clr_err = 1'b0;
    cfg_valid = 1'b0;
    chk("err_set_wins", 32'(err_addr), 32'd1);
    repeat (6) @(negedge clk);
    chk("illegal_no_write", 32'(wr_count), 32'd3);

    // Reset pulsed while the strobe is high.
    do_reset();
    send(10'b00000_10101, 1'b1, 1'b1);
    cfg_valid = 1'b0;
    t = 0;
    while (enable !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("reach_strobe", 32'(enable), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_enable_drop", 32'(enable), 32'd0);
    chk("async_busy_drop", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s0 = strobe_cnt;
    repeat (10) @(negedge clk);
    chk("abort_wr_count", 32'(wr_count), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // Counter wrap on the 4-bit instance: 17 writes.
    do_reset();
    for (int i = 0; i < 17; i++) send(mk_addr(5'(i % 20), 5'(i % 8)), 1'(i % 3), 1'b1);
    cfg_valid = 1'b0;
    wait_drain();
    chk("wrap_wr_count4", 32'(wr_count4), 32'd1);
    chk("wrap_wr_count16", 32'(wr_count), 32'd17);

    // Tile co-simulation: write inverted pattern, then the real one, read back.
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 20; s++)
        for (int w = 0; w < 8; w++)
          send(mk_addr(5'(s), 5'(w)), (p == 0) ? ~pat(s, w) : pat(s, w), 1'b1);
    cfg_valid = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);
    for (int s = 0; s < 20; s++)
      for (int w = 0; w < 8; w++)
        chk($sformatf("tile_%0d_%0d", s, w), 32'(tile_mem[s][w]), 32'(pat(s, w)));
    chk("tile_wr_count", 32'(wr_count), 32'd320);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
